branch_resolver: RTL
====================

# branch_resolver

Consumer end of the condition-code path: it reads the 3-bit NZP condition-code register output and resolves LC-3 BR instructions. Per branch it computes BEN and the target PC, then hands both to the PC-select logic through a valid/ready handshake. A hazard wait covers a CC update that is in flight in the same or recent cycles. The block sits between the instruction register, the NZP register and the PC mux.

## Interface
Parameters:
- W, 16, datapath width of IR, PC and target.
- CC_SETTLE, 1, cycles to wait after the last observed cc_ld before CC is read; must be ≥1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; low forces the reset state immediately.
- ir  in  W  instruction; bits [15:12] opcode, [11:9] n/z/p mask, [8:0] PCoffset9.
- ir_valid  in  1  request to resolve ir; accepted when ir_valid && ready at a clock edge.
- ready  out  1  block is idle and can accept.
- pc  in  W  incremented PC associated with ir; sampled at accept.
- cc  in  3  NZP register output; [2]=N, [1]=Z, [0]=P.
- cc_ld  in  1  LD_CC strobe; CC changes at the edge ending this cycle.
- br_valid  out  1  result available.
- br_ready  in  1  PC logic consumes result.
- br_taken  out  1  resolved BEN for the held result.
- br_target  out  W  pc + SEXT(offset9).
- ben  out  1  last resolved BEN, held until the next resolution.
- cc_err  out  1  the CC sampled for the held result was not one-hot.

## Operation
States: IDLE, WAIT_CC, RESOLVE, RESP.

**IDLE** (ready=1)
- On accept, latch ir[11:9], ir[8:0], pc and ir[15:12].
- Go to WAIT_CC if cc_ld=1 in the accept cycle or the settle counter is nonzero; otherwise go to RESOLVE.
- The settle counter loads CC_SETTLE on every cycle cc_ld=1, in any state, and decrements toward 0 otherwise.

**WAIT_CC**
- Stay while the counter ≠0 or cc_ld=1. A cc_ld during the wait reloads the counter.
- Go to RESOLVE when the counter =0 and cc_ld=0.

**RESOLVE** (one cycle)
- Register br_taken = ben = |(mask & cc), but only if the latched opcode = OP_BR; otherwise 0.
- Register br_target = latched pc + sign-extended offset9, mod 2^W (wrap-around: 16'hFFFF + 1 = 16'h0000).
- Register cc_err = (cc not in {100,010,001}).
- A non-one-hot CC still uses the mask AND. CC=000 (the NZP reset value) therefore yields not-taken.
- Go to RESP.

**RESP** (br_valid=1)
- br_taken, br_target and cc_err are stable until handshake.
- On br_valid && br_ready, go to IDLE. ready rises in the following cycle; no back-to-back accept in the handshake cycle.

General rules:
- mask=000 gives never-taken; mask=111 gives always-taken when CC is one-hot.
- cc_ld during RESOLVE or RESP does not alter the held result. It only reloads the counter.
- ir_valid outside IDLE is ignored. The requester must hold it until ready.

## Timing
- Reset values: ready=1 (state IDLE), br_valid=0, br_taken=0, br_target=0, ben=0, cc_err=0, counter=0.
- Reset asserted mid-operation aborts any request; the latched request is discarded.
- No hazard: accept at edge E0, RESOLVE during cycle E0–E1, br_valid high after E1. Minimum latency is 2 edges.
- With hazard: add CC_SETTLE cycles after the last cc_ld.
- Every output is driven from a register; there is no combinational path from inputs to outputs.
- ready is decoded from the state register.

## Structure
- Shared package slc3_pkg holds:
  - OP_BR = 4'b0000
  - CC index constants CC_N=2, CC_Z=1, CC_P=0
  - the resolver state enum
- One natural sub-module, branch_adder: W-bit pc plus 9-bit sign-extended offset, combinational.
- The FSM, counter and output registers live in branch_resolver.

## Test plan
- Reset released, cc=3'b000, ir=16'h0E05 (BRnzp +5), pc=16'h3001 → br_taken=0, cc_err=1, br_target=16'h3006, br_valid 2 edges after accept.
- cc=3'b010, ir=16'h0403 (BRz +3), pc=16'h3010, cc_ld=0 → br_taken=1, ben=1, target=16'h3013, cc_err=0.
- cc=3'b001, ir=16'h09FF (BRn -1), pc=16'h0000 → br_taken=0, target=16'hFFFF (wrap-around).
- Accept with cc_ld=1, then cc_ld=1 again in the next cycle, CC_SETTLE=1 → RESOLVE delayed; the CC sampled is the final value, and br_valid appears no earlier than 2 edges after the last cc_ld.
- Hold br_ready=0 for 5 cycles while cc changes 100→001 → br_valid, br_taken and br_target unchanged; ready=0 throughout; ready=1 one cycle after the handshake.
- Assert reset in WAIT_CC and in RESP → immediately br_valid=0, ready=1, ben=0; a new request after release resolves normally.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared LC-3 datapath constants and types for the branch path.
// Opcode, condition-code bit positions and resolver state encoding.
package slc3_pkg;

  localparam logic [3:0] OP_BR = 4'b0000;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_CC,
    S_RESOLVE,
    S_RESP
  } res_state_e;

  function automatic logic cc_onehot(input logic [2:0] c);
    return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
  endfunction

endpackage

// File: rtl/branch_adder.sv
// Branch target adder: pc plus sign-extended 9-bit offset.
// Wraps modulo 2^W.
module branch_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] pc,
  input  logic [8:0]   off,
  output logic [W-1:0] sum
);

  assign sum = pc + {{(W-9){off[8]}}, off};

endmodule

// File: rtl/branch_resolver.sv
// LC-3 BR resolver: waits for CC to settle, computes BEN and target,
// and presents them to the PC-select logic over valid/ready.
module branch_resolver
  import slc3_pkg::*;
#(
  parameter int W         = 16,
  parameter int CC_SETTLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] ir,
  input  logic         ir_valid,
  output logic         ready,
  input  logic [W-1:0] pc,
  input  logic [2:0]   cc,
  input  logic         cc_ld,
  output logic         br_valid,
  input  logic         br_ready,
  output logic         br_taken,
  output logic [W-1:0] br_target,
  output logic         ben,
  output logic         cc_err
);

  localparam int CW = $clog2(CC_SETTLE + 2);

  res_state_e   state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]   mask_q;
  logic [8:0]   off_q;
  logic [W-1:0] pc_q;
  logic [3:0]   op_q;
  logic         taken_q, ben_q, err_q;
  logic [W-1:0] target_q;
  logic [W-1:0] sum;
  logic         hit;

  branch_adder #(.W(W)) u_add (
    .pc (pc_q),
    .off(off_q),
    .sum(sum)
  );

  // Settle counter runs in every state so a CC write is never missed.
  always_comb begin
    cnt_d = cnt_q;
    if (cc_ld) begin
      cnt_d = CW'(CC_SETTLE);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign hit = (op_q == OP_BR) &&
               ((mask_q[CC_N] & cc[CC_N]) |
                (mask_q[CC_Z] & cc[CC_Z]) |
                (mask_q[CC_P] & cc[CC_P]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      off_q    <= '0;
      pc_q     <= '0;
      op_q     <= '0;
      taken_q  <= 1'b0;
      ben_q    <= 1'b0;
      err_q    <= 1'b0;
      target_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      unique case (state_q)
        S_IDLE: begin
          if (ir_valid) begin
            mask_q  <= ir[11:9];
            off_q   <= ir[8:0];
            pc_q    <= pc;
            op_q    <= ir[15:12];
            state_q <= (cc_ld || cnt_q != '0) ? S_WAIT_CC : S_RESOLVE;
          end
        end
        S_WAIT_CC: begin
          if (cnt_q == '0 && !cc_ld) state_q <= S_RESOLVE;
        end
        S_RESOLVE: begin
          taken_q  <= hit;
          ben_q    <= hit;
          target_q <= sum;
          err_q    <= !cc_onehot(cc);
          state_q  <= S_RESP;
        end
        S_RESP: begin
          if (br_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign br_valid  = (state_q == S_RESP);
  assign br_taken  = taken_q;
  assign br_target = target_q;
  assign ben       = ben_q;
  assign cc_err    = err_q;

endmodule
